// File: rtl/uart_tx_block.sv
// 8N1 UART transmitter: one-entry holding buffer feeding a start/data/stop
// shifter, each serial bit held for BIT_PERIOD clocks.
module uart_tx_block #(
  parameter int BIT_PERIOD = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       data_load,
  input  logic       error_clear,
  output logic       serial_out,
  output logic       buffer_full,
  output logic       tx_busy,
  output logic       frame_done,
  output logic       overrun_error
);

  localparam int CW = $clog2(BIT_PERIOD);
  localparam logic [CW-1:0] CNT_MAX = CW'(BIT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shift, shift_d;
  logic [7:0]    buf_data;
  logic          serial_d;
  logic          bit_end;
  logic          xfer;
  logic          load_ok;
  logic          overrun_set;

  assign bit_end     = (cnt == CNT_MAX);
  // The buffer empties into the shifter either from IDLE or at the very edge
  // that ends STOP, which is what makes zero-gap back-to-back frames possible.
  assign xfer        = buffer_full &&
                       ((state == IDLE) || ((state == STOP) && bit_end));
  assign load_ok     = data_load && (!buffer_full || xfer);
  assign overrun_set = data_load && buffer_full && !xfer;

  assign tx_busy     = (state != IDLE);
  assign frame_done  = (state == STOP) && bit_end;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state;
    cnt_d     = bit_end ? '0 : cnt + CW'(1);
    bit_idx_d = bit_idx;
    shift_d   = shift;
    serial_d  = 1'b1;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (buffer_full) begin
          state_d  = START;
          shift_d  = buf_data;
          serial_d = 1'b0;
        end
      end
      START: begin
        serial_d = 1'b0;
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          serial_d  = shift[0];
        end
      end
      DATA: begin
        serial_d = shift[0];
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_d  = STOP;
            serial_d = 1'b1;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            shift_d   = {1'b0, shift[7:1]};
            serial_d  = shift[1];
          end
        end
      end
      STOP: begin
        serial_d = 1'b1;
        if (bit_end) begin
          if (buffer_full) begin
            state_d  = START;
            shift_d  = buf_data;
            serial_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shift      <= 8'h00;
      serial_out <= 1'b1;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bit_idx    <= bit_idx_d;
      shift      <= shift_d;
      serial_out <= serial_d;
    end
  end

  // NOTE: the single-entry buffer is reset like any other flop; it is a
  // register, not a RAM, so clearing it costs nothing and aids debug.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      buf_data      <= 8'h00;
      buffer_full   <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      if (load_ok) begin
        buf_data    <= tx_data;
        buffer_full <= 1'b1;
      end else if (xfer) begin
        buffer_full <= 1'b0;
      end
      if (overrun_set)      overrun_error <= 1'b1;
      else if (error_clear) overrun_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_block.sv
// Directed bench for uart_tx_block: frame shape, back-to-back, overrun,
// same-edge reload, async reset mid-frame and a behavioural 8N1 receiver.
module tb_uart_tx_block;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] tx_data;
  logic       data_load;
  logic       error_clear;
  logic       serial_out;
  logic       buffer_full;
  logic       tx_busy;
  logic       frame_done;
  logic       overrun_error;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_block #(.BIT_PERIOD(10)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .tx_data      (tx_data),
    .data_load    (data_load),
    .error_clear  (error_clear),
    .serial_out   (serial_out),
    .buffer_full  (buffer_full),
    .tx_busy      (tx_busy),
    .frame_done   (frame_done),
    .overrun_error(overrun_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [99:0] obs, input logic [99:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected line for one frame, one entry per clock, BIT_PERIOD = 10.
  function automatic logic [99:0] frame_bits(input logic [7:0] b);
    logic [99:0] v;
    int k;
    for (int i = 0; i < 100; i++) begin
      k = i / 10;
      if (k == 0)      v[i] = 1'b0;
      else if (k == 9) v[i] = 1'b1;
      else             v[i] = b[k-1];
    end
    return v;
  endfunction

  // Samples 100 clocks starting at the current negedge (first start-bit clock).
  // Optionally drives a one-clock load after the sample at index ld_at.
  task automatic capture(output logic [99:0] line, output logic [99:0] done,
                         output logic [99:0] busy, input int ld_at,
                         input logic [7:0] ld_byte);
    for (int i = 0; i < 100; i++) begin
      line[i] = serial_out;
      done[i] = frame_done;
      busy[i] = tx_busy;
      data_load = (i == ld_at);
      if (i == ld_at) tx_data = ld_byte;
      if (i < 99) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!tx_busy && !buffer_full) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(tag, {99'd0, ok}, 100'd1);
  endtask

  // Behavioural 8N1 receiver: find the start edge, sample mid-bit.
  task automatic rx_byte(output logic [7:0] d, output logic ferr, output logic tmo);
    d = 8'h00;
    ferr = 1'b0;
    tmo = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (serial_out === 1'b0) begin
        tmo = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (!tmo) begin
      repeat (4) @(negedge clk);
      if (serial_out !== 1'b0) ferr = 1'b1;
      for (int b = 0; b < 8; b++) begin
        repeat (10) @(negedge clk);
        d[b] = serial_out;
      end
      repeat (10) @(negedge clk);
      if (serial_out !== 1'b1) ferr = 1'b1;
    end
  endtask

  task automatic load_byte(input logic [7:0] b);
    data_load = 1'b1;
    tx_data   = b;
    @(negedge clk);
    data_load = 1'b0;
  endtask

  logic [99:0] line, done, busy;
  logic [99:0] done_exp;
  logic [7:0]  rx_d;
  logic        rx_ferr, rx_tmo, saw_low;
  logic [7:0]  lb_bytes [5] = '{8'h00, 8'h55, 8'hAA, 8'hFF, 8'h81};

  initial begin
    done_exp     = '0;
    done_exp[99] = 1'b1;
    n_rst       = 1'b0;
    tx_data     = 8'h00;
    data_load   = 1'b0;
    error_clear = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("reset_flags", {95'd0, serial_out, buffer_full, tx_busy, frame_done, overrun_error},
          100'b10000);

    // 1: single frame 0xA5 from IDLE
    load_byte(8'hA5);
    check("t1_after_load", {97'd0, buffer_full, serial_out, tx_busy}, 100'b110);
    @(negedge clk);
    check("t1_bf_cleared", {99'd0, buffer_full}, 100'd0);
    capture(line, done, busy, -1, 8'h00);
    check("t1_line", line, frame_bits(8'hA5));
    check("t1_done", done, done_exp);
    check("t1_busy", busy, '1);
    @(negedge clk);
    check("t1_idle", {98'd0, serial_out, tx_busy}, 100'b10);

    // 2: back-to-back 0x00 then 0xFF
    load_byte(8'h00);
    @(negedge clk);
    capture(line, done, busy, 0, 8'hFF);
    check("t2_line0", line, frame_bits(8'h00));
    check("t2_busy0", busy, '1);
    @(negedge clk);
    capture(line, done, busy, -1, 8'h00);
    check("t2_line1", line, frame_bits(8'hFF));
    check("t2_busy1", busy, '1);
    check("t2_ovr", {99'd0, overrun_error}, 100'd0);
    @(negedge clk);

    // 3: overrun, error clear, and set-wins-over-clear
    load_byte(8'h11);
    @(negedge clk);
    data_load = 1'b1;
    tx_data   = 8'h22;
    @(negedge clk);
    check("t3_pre_ovr", {98'd0, buffer_full, overrun_error}, 100'b10);
    tx_data = 8'h33;
    @(negedge clk);
    data_load = 1'b0;
    check("t3_ovr_set", {98'd0, buffer_full, overrun_error}, 100'b11);
    repeat (98) @(negedge clk);
    capture(line, done, busy, -1, 8'h00);
    check("t3_second_frame", line, frame_bits(8'h22));
    @(negedge clk);
    check("t3_no_third", {98'd0, tx_busy, buffer_full}, 100'd0);
    error_clear = 1'b1;
    @(negedge clk);
    error_clear = 1'b0;
    check("t3_cleared", {99'd0, overrun_error}, 100'd0);
    load_byte(8'h44);
    data_load = 1'b1;
    tx_data   = 8'h55;
    @(negedge clk);
    tx_data     = 8'h66;
    error_clear = 1'b1;
    @(negedge clk);
    data_load   = 1'b0;
    error_clear = 1'b0;
    check("t3_set_wins", {99'd0, overrun_error}, 100'd1);
    wait_idle("t3_drain");
    error_clear = 1'b1;
    @(negedge clk);
    error_clear = 1'b0;

    // 4: load on the edge that ends STOP with the buffer full
    load_byte(8'h3C);
    data_load = 1'b1;
    tx_data   = 8'hC3;
    @(negedge clk);
    check("t4_bf_c1", {98'd0, buffer_full, overrun_error}, 100'b10);
    capture(line, done, busy, 99, 8'h96);
    check("t4_line0", line, frame_bits(8'h3C));
    @(negedge clk);
    check("t4_bf_kept", {98'd0, buffer_full, overrun_error}, 100'b10);
    capture(line, done, busy, -1, 8'h00);
    check("t4_line1", line, frame_bits(8'hC3));
    @(negedge clk);
    capture(line, done, busy, -1, 8'h00);
    check("t4_line2", line, frame_bits(8'h96));
    check("t4_ovr", {99'd0, overrun_error}, 100'd0);
    @(negedge clk);

    // 5: async reset in data bit 4 of 0x5A
    load_byte(8'h5A);
    @(negedge clk);
    repeat (54) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("t5_reset_flags", {95'd0, serial_out, buffer_full, tx_busy, frame_done, overrun_error},
          100'b10000);
    @(negedge clk);
    n_rst = 1'b1;
    saw_low = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || tx_busy !== 1'b0) saw_low = 1'b1;
    end
    check("t5_stays_idle", {99'd0, saw_low}, 100'd0);
    load_byte(8'h5A);
    @(negedge clk);
    capture(line, done, busy, -1, 8'h00);
    check("t5_line", line, frame_bits(8'h5A));
    check("t5_done", done, done_exp);
    @(negedge clk);

    // 6: loopback into a behavioural receiver
    for (int n = 0; n < 5; n++) begin
      load_byte(lb_bytes[n]);
      rx_byte(rx_d, rx_ferr, rx_tmo);
      check($sformatf("t6_rx_%0d", n), {90'd0, rx_tmo, rx_ferr, rx_d}, {92'd0, lb_bytes[n]});
    end
    wait_idle("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
